ifu_fetch: RTL

- Instruction fetch stage of the single-issue RV32I core; sits directly upstream of decode and the immediate generator.
- Owns the PC and issues word fetches to instruction memory through a request/grant/response handshake.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode on a valid/ready interface.
- Accepts a redirect (branch/jump target from execute) that flushes everything fetched down the wrong path.

---
 rtl/ifu_fetch_if.sv | 25 ++
 rtl/ifu_fetch.sv | 109 ++++++++++
 2 files changed

// File: rtl/ifu_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory handshake, decode-side
// instruction stream and the redirect input from execute.
interface ifu_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, inst_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_gnt, imem_rvalid, imem_rdata, inst_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ifu_fetch.sv
// RV32I instruction fetch: owns the PC, keeps one memory request in flight,
// buffers returned words with their PCs, and flushes on redirect.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  ifu_fetch_if.master  bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [31:0]   NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_DROP} state_t;

  state_t          state;
  logic [31:0]     pc;
  logic [31:0]     req_pc;
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [CW-1:0]   count;
  logic [31:0]     buf_inst [FIFO_DEPTH];
  logic [31:0]     buf_pc   [FIFO_DEPTH];

  logic            full;
  logic            req;
  logic            accept;
  logic            push;
  logic            pop;
  logic            redir;
  logic [31:0]     redir_pc;

  assign redir    = bus.redirect_valid;
  assign redir_pc = {bus.redirect_pc[31:2], 2'b00};
  assign full     = (count == DEPTH_C);

  // Requests only when the outstanding response is guaranteed a free slot;
  // the registered count is used so inst_ready never reaches imem_req.
  assign req    = rst_n && (state == S_RUN) && !full && !redir;
  assign accept = req && bus.imem_gnt;
  assign push   = (state == S_WAIT) && bus.imem_rvalid && !redir;
  assign pop    = (count != '0) && bus.inst_ready && !redir;

  assign bus.imem_req  = req;
  assign bus.imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_RUN;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
    end else if (redir) begin
      pc <= redir_pc;
      // A stale response still in flight must be swallowed in DROP.
      case (state)
        S_WAIT:  state <= bus.imem_rvalid ? S_RUN : S_DROP;
        S_DROP:  state <= bus.imem_rvalid ? S_RUN : S_DROP;
        default: state <= S_RUN;
      endcase
    end else begin
      case (state)
        S_RUN: if (accept) begin
          req_pc <= pc;
          pc     <= pc + 32'd4;
          state  <= S_WAIT;
        end
        S_WAIT:  if (bus.imem_rvalid) state <= S_RUN;
        S_DROP:  if (bus.imem_rvalid) state <= S_RUN;
        default: state <= S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (redir) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_inst[wptr] <= bus.imem_rdata;
      buf_pc[wptr]   <= req_pc;
    end
  end

  assign bus.inst_valid = (count != '0);
  assign bus.inst       = (count != '0) ? buf_inst[rptr] : NOP;
  assign bus.inst_pc    = (count != '0) ? buf_pc[rptr]   : 32'h0;

  logic unused_ok;
  assign unused_ok = &{1'b0, bus.redirect_pc[1:0]};

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule
